// File: rtl/iec_sd_sector_server.sv
// Sector responder for up to four IEC drives: round-robin arbitration of sd_rd/sd_wr
// requests, 512-byte transfers between the drive buffers and a byte-wide image memory.
module iec_sd_sector_server #(
    parameter int NDR    = 2,
    parameter int LBA_W  = 11,
    parameter int MEM_AW = 22
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [32*NDR-1:0]        sd_lba,
    input  logic [NDR-1:0]           sd_rd,
    input  logic [NDR-1:0]           sd_wr,
    output logic [NDR-1:0]           sd_ack,
    output logic [8:0]               sd_buff_addr,
    output logic [7:0]               sd_buff_dout,
    output logic                     sd_buff_wr,
    input  logic [8*NDR-1:0]         sd_buff_din,
    input  logic [(LBA_W+1)*NDR-1:0] img_sectors,
    output logic [MEM_AW-1:0]        mem_addr,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [7:0]               mem_wdata,
    input  logic [7:0]               mem_rdata,
    input  logic                     mem_ready,
    output logic                     busy
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_RD_REQ,
        S_RD_PUT,
        S_RD_ADV,
        S_WR_ADDR,
        S_WR_WAIT,
        S_WR_CAP,
        S_WR_REQ,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [1:0]         rr_q;
    logic [1:0]         drv_q;
    logic               wr_op_q;
    logic [31:0]        lba_q;
    logic               oor_q;
    logic [9:0]         b_q;
    logic [NDR-1:0]     ack_q;
    logic               busy_q;
    logic [8:0]         buff_addr_q;
    logic [7:0]         buff_dout_q;
    logic               buff_wr_q;
    logic [MEM_AW-1:0]  mem_addr_q;
    logic               mem_req_q;
    logic               mem_we_q;
    logic [7:0]         mem_wdata_q;

    // Per-drive views padded to four slots so a 2-bit drive index is always in range.
    logic [31:0]        lba_arr [4];
    logic [7:0]         din_arr [4];
    logic [LBA_W:0]     img_arr [4];
    logic [3:0]         req_arr;
    logic [3:0]         wreq_arr;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_drv
            if (gi < NDR) begin : g_on
                assign lba_arr[gi]  = sd_lba[32*gi +: 32];
                assign din_arr[gi]  = sd_buff_din[8*gi +: 8];
                assign img_arr[gi]  = img_sectors[(LBA_W+1)*gi +: (LBA_W+1)];
                assign req_arr[gi]  = sd_rd[gi] | sd_wr[gi];
                assign wreq_arr[gi] = sd_wr[gi];
            end else begin : g_off
                assign lba_arr[gi]  = '0;
                assign din_arr[gi]  = '0;
                assign img_arr[gi]  = '0;
                assign req_arr[gi]  = 1'b0;
                assign wreq_arr[gi] = 1'b0;
            end
        end
    endgenerate

    logic               found_d;
    logic [1:0]         win_d;
    logic [1:0]         rr_next_d;
    logic [2:0]         cand_d;
    logic [2:0]         nxt_d;

    // Scan NDR slots starting at the round-robin pointer; first requester wins.
    always_comb begin
        found_d   = 1'b0;
        win_d     = '0;
        cand_d    = '0;
        nxt_d     = '0;
        rr_next_d = '0;
        for (int k = 0; k < 4; k++) begin
            if (k < NDR) begin
                cand_d = {1'b0, rr_q} + 3'(k);
                if (cand_d >= 3'(NDR)) begin
                    cand_d = cand_d - 3'(NDR);
                end
                if (!found_d && req_arr[cand_d[1:0]]) begin
                    found_d = 1'b1;
                    win_d   = cand_d[1:0];
                end
            end
        end
        nxt_d = {1'b0, win_d} + 3'd1;
        if (nxt_d >= 3'(NDR)) begin
            nxt_d = '0;
        end
        rr_next_d = nxt_d[1:0];
    end

    logic [LBA_W:0]     img_sel_d;
    logic               oor_d;
    logic [7:0]         din_sel_d;
    logic [MEM_AW-1:0]  mem_addr_d;
    logic               last_d;

    assign img_sel_d  = img_arr[drv_q];
    assign oor_d      = (lba_q[31:LBA_W] != '0) || (lba_q >= 32'(img_sel_d));
    assign din_sel_d  = din_arr[drv_q];
    assign mem_addr_d = MEM_AW'({drv_q, lba_q[LBA_W-1:0], b_q[8:0]});
    assign last_d     = (b_q == 10'd511);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            rr_q        <= '0;
            drv_q       <= '0;
            wr_op_q     <= 1'b0;
            lba_q       <= '0;
            oor_q       <= 1'b0;
            b_q         <= '0;
            ack_q       <= '0;
            busy_q      <= 1'b0;
            buff_addr_q <= '0;
            buff_dout_q <= '0;
            buff_wr_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            buff_wr_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (found_d) begin
                        drv_q   <= win_d;
                        wr_op_q <= wreq_arr[win_d];
                        lba_q   <= lba_arr[win_d];
                        rr_q    <= rr_next_d;
                        ack_q   <= NDR'(4'b0001 << win_d);
                        busy_q  <= 1'b1;
                        b_q     <= '0;
                        state_q <= S_START;
                    end
                end
                // Range is decided once per transfer from the latched lba.
                S_START: begin
                    oor_q <= oor_d;
                    if (wr_op_q) begin
                        buff_addr_q <= '0;
                        state_q     <= S_WR_ADDR;
                    end else begin
                        mem_req_q  <= !oor_d;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= mem_addr_d;
                        state_q    <= S_RD_REQ;
                    end
                end
                S_RD_REQ: begin
                    if (oor_q || mem_ready) begin
                        mem_req_q   <= 1'b0;
                        buff_addr_q <= b_q[8:0];
                        buff_dout_q <= oor_q ? 8'h00 : mem_rdata;
                        buff_wr_q   <= 1'b1;
                        state_q     <= S_RD_PUT;
                    end
                end
                S_RD_PUT: begin
                    if (last_d) begin
                        ack_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end else begin
                        b_q     <= b_q + 10'd1;
                        state_q <= S_RD_ADV;
                    end
                end
                S_RD_ADV: begin
                    mem_req_q  <= !oor_q;
                    mem_addr_q <= mem_addr_d;
                    state_q    <= S_RD_REQ;
                end
                // Drive buffer data arrives two clocks after sd_buff_addr moves.
                S_WR_ADDR: state_q <= S_WR_WAIT;
                S_WR_WAIT: state_q <= S_WR_CAP;
                S_WR_CAP: begin
                    mem_wdata_q <= din_sel_d;
                    mem_we_q    <= 1'b1;
                    mem_addr_q  <= mem_addr_d;
                    mem_req_q   <= !oor_q;
                    state_q     <= S_WR_REQ;
                end
                S_WR_REQ: begin
                    if (oor_q || mem_ready) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        if (last_d) begin
                            ack_q   <= '0;
                            busy_q  <= 1'b0;
                            state_q <= S_DONE;
                        end else begin
                            b_q         <= b_q + 10'd1;
                            buff_addr_q <= b_q[8:0] + 9'd1;
                            state_q     <= S_WR_ADDR;
                        end
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign sd_ack       = ack_q;
    assign busy         = busy_q;
    assign sd_buff_addr = buff_addr_q;
    assign sd_buff_dout = buff_dout_q;
    assign sd_buff_wr   = buff_wr_q;
    assign mem_addr     = mem_addr_q;
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_iec_sd_sector_server.sv
// Randomised bench for iec_sd_sector_server: memory and drive-buffer models plus a
// sector-level reference of expected bytes, memory writes and grant order.
`timescale 1ns/1ps
module tb_iec_sd_sector_server;
    localparam int NDR    = 2;
    localparam int LBA_W  = 11;
    localparam int MEM_AW = 22;

    logic                     clk = 1'b0;
    logic                     reset_n = 1'b0;
    logic [32*NDR-1:0]        sd_lba = '0;
    logic [NDR-1:0]           sd_rd = '0;
    logic [NDR-1:0]           sd_wr = '0;
    logic [NDR-1:0]           sd_ack;
    logic [8:0]               sd_buff_addr;
    logic [7:0]               sd_buff_dout;
    logic                     sd_buff_wr;
    logic [8*NDR-1:0]         sd_buff_din;
    logic [(LBA_W+1)*NDR-1:0] img_sectors = '0;
    logic [MEM_AW-1:0]        mem_addr;
    logic                     mem_req;
    logic                     mem_we;
    logic [7:0]               mem_wdata;
    logic [7:0]               mem_rdata = '0;
    logic                     mem_ready = 1'b1;
    logic                     busy;

    iec_sd_sector_server #(.NDR(NDR), .LBA_W(LBA_W), .MEM_AW(MEM_AW)) dut (
        .clk(clk), .reset_n(reset_n), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
        .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
        .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din), .img_sectors(img_sectors),
        .mem_addr(mem_addr), .mem_req(mem_req), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Image memory: preload pattern mem[a] = a[7:0] ^ lba[7:0]; DUT writes go to phys_mem,
    // the reference keeps its own copy of what should have been written.
    logic [7:0] phys_mem [int];
    logic [7:0] ref_mem [int];

    function automatic logic [7:0] init_byte(int a);
        logic [31:0] v;
        v = a;
        return v[7:0] ^ v[16:9];
    endfunction

    function automatic logic [7:0] phys_rd(int a);
        if (phys_mem.exists(a)) return phys_mem[a];
        return init_byte(a);
    endfunction

    function automatic logic [7:0] ref_rd(int a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_byte(a);
    endfunction

    function automatic int sec_addr(int d, logic [31:0] lba, int i);
        return (d << 20) | (int'(lba[10:0]) << 9) | i;
    endfunction

    always @(negedge clk or mem_addr) mem_rdata = phys_rd(int'(mem_addr));

    // Drive buffers: two-clock read latency, drive 0 returns addr^0x5A, drive 1 ~addr.
    function automatic logic [7:0] drv_byte(int d, logic [8:0] a);
        return (d == 0) ? (a[7:0] ^ 8'h5A) : ~a[7:0];
    endfunction

    logic [8:0] p1 = '0;
    logic [8:0] p2 = '0;
    always @(posedge clk) begin
        p1 <= sd_buff_addr;
        p2 <= p1;
    end
    assign sd_buff_din = {drv_byte(1, p2), drv_byte(0, p2)};

    bit stall_en = 1'b0;
    initial forever begin
        @(posedge clk);
        #1;
        mem_ready = stall_en ? ($urandom_range(0, 9) < 3) : 1'b1;
    end

    logic [8:0]        cap_addr [$];
    logic [7:0]        cap_data [$];
    logic [MEM_AW-1:0] mw_addr [$];
    logic [7:0]        mw_data [$];
    int                grant_q [$];
    int                n_hs = 0;
    int                n_req_cyc = 0;
    int                stab_viol = 0;
    int                ack_viol = 0;
    int                rst_activity = 0;

    initial begin : monitor
        logic              wait_prev;
        logic [MEM_AW-1:0] addr_prev;
        logic              we_prev;
        logic [7:0]        wd_prev;
        logic [NDR-1:0]    ack_prev;
        wait_prev = 1'b0;
        addr_prev = '0;
        we_prev   = 1'b0;
        wd_prev   = '0;
        ack_prev  = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                if (mem_req || sd_buff_wr) rst_activity++;
                wait_prev = 1'b0;
                ack_prev  = sd_ack;
            end else begin
                if (sd_buff_wr) begin
                    cap_addr.push_back(sd_buff_addr);
                    cap_data.push_back(sd_buff_dout);
                end
                if (mem_req) n_req_cyc++;
                if (wait_prev && (!mem_req || mem_addr !== addr_prev ||
                                  mem_we !== we_prev || mem_wdata !== wd_prev))
                    stab_viol++;
                if (mem_req && mem_ready) begin
                    n_hs++;
                    if (mem_we) begin
                        mw_addr.push_back(mem_addr);
                        mw_data.push_back(mem_wdata);
                        phys_mem[int'(mem_addr)] = mem_wdata;
                    end
                end
                wait_prev = mem_req && !mem_ready;
                addr_prev = mem_addr;
                we_prev   = mem_we;
                wd_prev   = mem_wdata;
                if ($countones(sd_ack) > 1) ack_viol++;
                for (int i = 0; i < NDR; i++)
                    if (sd_ack[i] && !ack_prev[i]) grant_q.push_back(i);
                ack_prev = sd_ack;
            end
        end
    end

    task automatic clear_caps();
        cap_addr.delete();
        cap_data.delete();
        mw_addr.delete();
        mw_data.delete();
        n_hs = 0;
        n_req_cyc = 0;
        stab_viol = 0;
    endtask

    task automatic check_outs_zero(input string tag);
        check(tag, {sd_ack, busy, mem_req, mem_we, sd_buff_wr, sd_buff_addr,
                    sd_buff_dout, mem_wdata, mem_addr}, 64'd0);
    endtask

    // One full sector transfer, then compare against the sector-level reference.
    task automatic xfer(input int d, input bit wr, input logic [31:0] lba, input logic [LBA_W:0] img);
        int  t;
        bit  oor;
        int  errs;
        int  a;
        @(negedge clk);
        clear_caps();
        img_sectors[d*(LBA_W+1) +: (LBA_W+1)] = img;
        sd_lba[d*32 +: 32] = lba;
        if (wr) sd_wr[d] = 1'b1;
        else    sd_rd[d] = 1'b1;
        t = 0;
        while (!sd_ack[d] && t < 50) begin @(negedge clk); t++; end
        check("grant", 64'(sd_ack[d]), 64'd1);
        check("busy_on_grant", 64'(busy), 64'd1);
        sd_rd[d] = 1'b0;
        sd_wr[d] = 1'b0;
        sd_lba[d*32 +: 32] = $urandom;
        t = 0;
        while (sd_ack[d] && t < 20000) begin @(negedge clk); t++; end
        check("ack_release", 64'(sd_ack[d]), 64'd0);

        oor  = (lba >= 32'(img)) || (lba >= 32'(1 << LBA_W));
        errs = 0;
        if (!wr) begin
            check("rd_count", 64'(cap_addr.size()), 64'd512);
            check("rd_no_memwr", 64'(mw_addr.size()), 64'd0);
            for (int i = 0; i < cap_addr.size() && i < 512; i++) begin
                a = sec_addr(d, lba, i);
                if (cap_addr[i] !== 9'(i) || cap_data[i] !== (oor ? 8'h00 : ref_rd(a))) errs++;
            end
            check("rd_bad_bytes", 64'(errs), 64'd0);
            if (oor) check("rd_oor_memreq", 64'(n_req_cyc), 64'd0);
            else     check("rd_mem_reads", 64'(n_hs), 64'd512);
        end else begin
            check("wr_no_buffwr", 64'(cap_addr.size()), 64'd0);
            check("wr_count", 64'(mw_addr.size()), oor ? 64'd0 : 64'd512);
            if (oor) check("wr_oor_memreq", 64'(n_req_cyc), 64'd0);
            for (int i = 0; i < mw_addr.size() && i < 512; i++) begin
                a = sec_addr(d, lba, i);
                if (int'(mw_addr[i]) != a || mw_data[i] !== drv_byte(d, 9'(i))) errs++;
            end
            check("wr_bad_bytes", 64'(errs), 64'd0);
            if (!oor)
                for (int i = 0; i < 512; i++) ref_mem[sec_addr(d, lba, i)] = drv_byte(d, 9'(i));
        end
        check("stall_stable", 64'(stab_viol), 64'd0);
        check("ack_onehot", 64'(ack_viol), 64'd0);
        $display("xfer drv=%0d %s lba=0x%0h img=%0d oor=%0d stall=%0d bytes=%0d memops=%0d",
                 d, wr ? "WR" : "RD", lba, img, oor, stall_en, cap_addr.size(), n_hs);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int t;
        int rr;
        int exp_g;
        int got_g;
        bit wr;
        int d;
        int kind;
        logic [LBA_W:0] img;
        logic [31:0] lba;

        repeat (3) @(negedge clk);
        check_outs_zero("reset_outputs");
        reset_n = 1'b1;
        img_sectors = {12'd800, 12'd800};

        // Basic read and write sectors.
        xfer(0, 1'b0, 32'd5, 12'd800);
        xfer(1, 1'b1, 32'd3, 12'd800);

        // Simultaneous requests after reset: round-robin from drive 0.
        pulse_reset();
        @(negedge clk);
        grant_q.delete();
        img_sectors = {12'd800, 12'd800};
        sd_lba = {32'd7, 32'd5};
        sd_rd  = 2'b11;
        t = 0;
        while (grant_q.size() < 4 && t < 30000) begin @(negedge clk); t++; end
        sd_rd = 2'b00;
        t = 0;
        while ((busy || sd_ack != '0) && t < 5000) begin @(negedge clk); t++; end
        check("arb_grants", 64'(grant_q.size()), 64'd4);
        rr = 0;
        for (int k = 0; k < 4; k++) begin
            exp_g = rr;
            rr    = (exp_g + 1) % NDR;
            got_g = (k < grant_q.size()) ? grant_q[k] : 99;
            check($sformatf("arb_order%0d", k), 64'(got_g), 64'(exp_g));
        end
        $display("arb grants=%p", grant_q);

        // Range boundaries.
        xfer(0, 1'b0, 32'd800, 12'd800);
        xfer(0, 1'b0, 32'd800, 12'd0);
        xfer(1, 1'b1, 32'h0010_0003, 12'd800);

        // Stalled memory: same read data as the unstalled case.
        stall_en = 1'b1;
        xfer(0, 1'b0, 32'd5, 12'd800);
        stall_en = 1'b0;

        // Reset in the middle of a read, then a clean read.
        @(negedge clk);
        clear_caps();
        img_sectors[0 +: 12] = 12'd800;
        sd_lba[0 +: 32] = 32'd9;
        sd_rd[0] = 1'b1;
        t = 0;
        while (cap_addr.size() < 100 && t < 2000) begin @(negedge clk); t++; end
        check("rst_reached_byte100", 64'(cap_addr.size() >= 100), 64'd1);
        sd_rd[0] = 1'b0;
        rst_activity = 0;
        reset_n = 1'b0;
        #1;
        check_outs_zero("rst_midxfer_outputs");
        repeat (5) @(negedge clk);
        check("rst_quiet", 64'(rst_activity), 64'd0);
        reset_n = 1'b1;
        xfer(0, 1'b0, 32'd9, 12'd800);

        // Random mix of drives, ops, ranges and stalls.
        for (int r = 0; r < 6; r++) begin
            d    = $urandom_range(0, NDR - 1);
            wr   = 1'($urandom_range(0, 1));
            img  = 12'($urandom_range(0, 3000));
            kind = $urandom_range(0, 3);
            if (kind <= 1) lba = (img == 0) ? 32'd0 : 32'($urandom_range(0, (img > 2048 ? 2048 : int'(img)) - 1));
            else if (kind == 2) lba = 32'(img);
            else lba = 32'h1000_0000 | 32'($urandom_range(0, 15));
            stall_en = 1'($urandom_range(0, 1));
            xfer(d, wr, lba, img);
        end
        stall_en = 1'b0;

        // Read back a sector written earlier through the same path.
        xfer(1, 1'b0, 32'd3, 12'd800);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
